aes_top: RTL and testbench



---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_top.sv | 147 ++++++++++++++
 tb/tb_aes_top.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the iterative core.
package aes_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } aes_state_e;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam logic [3:0]  LAST_RND   = 4'(NUM_ROUNDS);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Byte 0 of the column sits in bits [31:24].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte index 4*c+r lives at bits [127-8*idx -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 S-box: multiplicative inverse (x^254) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

    // Addition chain to x^254; zero maps to zero as the S-box requires.
    assign w_x2   = gf_mul(i_data, i_data);
    assign w_x3   = gf_mul(w_x2, i_data);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign w_x252 = gf_mul(w_x240, w_x12);
    assign w_inv  = gf_mul(w_x252, w_x2);

    assign o_data = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryption of a fixed plaintext, one round per clock, key expanded on the fly.
module aes_top
    import aes_pkg::*;
#(
    parameter logic [127:0] PLAINTEXT = 128'h3243f6a8885a308d313198a2e0370734
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    output logic [127:0] out,
    input  logic         __obs
);

    aes_state_e   r_fsm;
    aes_state_e   w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [127:0] r_out;
    logic [3:0]   r_rnd;
    logic [7:0]   r_rcon;

    logic         w_load;
    logic         w_step;
    logic         w_done;
    logic         w_last;
    logic [127:0] w_sub;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_next_rk;
    logic [127:0] w_round_out;
    logic [31:0]  w_rot;
    logic [31:0]  w_subword;
    logic [31:0]  w_t;

    genvar g;

    for (g = 0; g < 16; g++) begin : g_state_sbox
        aes_sbox u_sbox (
            .i_data (r_state[127 - 8 * g -: 8]),
            .o_data (w_sub[127 - 8 * g -: 8])
        );
    end

    assign w_rot = rot_word(r_rk[31:0]);

    for (g = 0; g < 4; g++) begin : g_key_sbox
        aes_sbox u_sbox (
            .i_data (w_rot[31 - 8 * g -: 8]),
            .o_data (w_subword[31 - 8 * g -: 8])
        );
    end

    assign w_sr = shift_rows(w_sub);

    for (g = 0; g < 4; g++) begin : g_mix
        assign w_mc[127 - 32 * g -: 32] = mix_column(w_sr[127 - 32 * g -: 32]);
    end

    // Each new key word chains off the previous new word.
    assign w_t                = w_subword ^ {r_rcon, 24'h000000};
    assign w_next_rk[127:96]  = r_rk[127:96] ^ w_t;
    assign w_next_rk[95:64]   = r_rk[95:64]  ^ w_next_rk[127:96];
    assign w_next_rk[63:32]   = r_rk[63:32]  ^ w_next_rk[95:64];
    assign w_next_rk[31:0]    = r_rk[31:0]   ^ w_next_rk[63:32];

    assign w_last      = (r_rnd == LAST_RND);
    assign w_round_out = (w_last ? w_sr : w_mc) ^ w_next_rk;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:    w_fsm_next = __obs ? RUN : IDLE;
            RUN:     w_fsm_next = w_last ? IDLE : RUN;
            default: w_fsm_next = IDLE;
        endcase
    end

    // FSM control outputs.
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_done = 1'b0;
        case (r_fsm)
            IDLE: begin
                w_load = __obs;
            end
            RUN: begin
                w_step = 1'b1;
                w_done = w_last;
            end
            default: begin
                w_load = 1'b0;
                w_step = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Round datapath: initial AddRoundKey on load, then one full round per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= 128'h0;
            r_rk    <= 128'h0;
            r_rnd   <= 4'd0;
            r_rcon  <= 8'h00;
        end else if (w_load) begin
            r_state <= PLAINTEXT ^ key;
            r_rk    <= key;
            r_rnd   <= 4'd1;
            r_rcon  <= 8'h01;
        end else if (w_step) begin
            r_state <= w_round_out;
            r_rk    <= w_next_rk;
            r_rnd   <= r_rnd + 4'd1;
            r_rcon  <= xtime(r_rcon);
        end else begin
            r_state <= r_state;
            r_rk    <= r_rk;
            r_rnd   <= r_rnd;
            r_rcon  <= r_rcon;
        end
    end

    // Ciphertext register, written only when the last round completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 128'h0;
        end else if (w_done) begin
            r_out <= w_round_out;
        end else begin
            r_out <= r_out;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: three plaintext variants against a byte-array AES reference.
module tb_aes_top;

    localparam logic [127:0] PT_DEF  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PT_ZERO = 128'h0;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         obs = 1'b0;
    logic [127:0] key = 128'h0;
    logic [127:0] out_def, out_zero, out_fips;

    int total = 0;
    int bad   = 0;

    logic [7:0] sbox_tab [256];

    aes_top u_dut  (.clk(clk), .rst(rst), .key(key), .out(out_def),  .__obs(obs));
    aes_top #(.PLAINTEXT(PT_ZERO)) u_zero (.clk(clk), .rst(rst), .key(key), .out(out_zero), .__obs(obs));
    aes_top #(.PLAINTEXT(PT_FIPS)) u_fips (.clk(clk), .rst(rst), .key(key), .out(out_fips), .__obs(obs));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: brute-force inverse, then bitwise affine map.
    task automatic build_sbox();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ k[127 - 8 * i -: 8];
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4 * c + r] = s[4 * ((c + r) % 4) + r];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = m_mul(8'h02, t[4*c]) ^ m_mul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ m_mul(8'h02, t[4*c+1]) ^ m_mul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ m_mul(8'h02, t[4*c+2]) ^ m_mul(8'h03, t[4*c+3]);
                    s[4*c+3] = m_mul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ m_mul(8'h02, t[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
                tmp = w[4 * rd + c];
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ tmp[31 - 8 * r -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        obs = 1'b0;
        tick();
        tick();
        total++;
        if (out_def !== 128'h0 || out_zero !== 128'h0 || out_fips !== 128'h0) begin
            bad++;
            $display("FAIL reset_value: got %h/%h/%h want 0", out_def, out_zero, out_fips);
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            key = rand128();
            tick();
            total++;
            if (out_def !== 128'h0 || out_zero !== 128'h0 || out_fips !== 128'h0) begin
                bad++;
                $display("FAIL idle_hold cyc %0d: got %h/%h/%h want 0", i, out_def, out_zero, out_fips);
            end
        end
    endtask

    task automatic test_kat_default();
        logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        logic [127:0] prev = out_def;
        key = k;
        obs = 1'b1;
        tick();
        obs = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            key = rand128();
            tick();
            total++;
            if (e < 10 && out_def !== prev) begin
                bad++;
                $display("FAIL kat_early edge %0d: got %h want %h", e, out_def, prev);
            end else if (e == 10 && out_def !== 128'h3925841d02dc09fbdc118597196a0b32) begin
                bad++;
                $display("FAIL kat_default: got %h want 3925841d02dc09fbdc118597196a0b32", out_def);
            end
        end
        total++;
        if (out_fips !== aes_model(PT_FIPS, k)) begin
            bad++;
            $display("FAIL kat_default_fips_inst: got %h want %h", out_fips, aes_model(PT_FIPS, k));
        end
        for (int i = 0; i < 3; i++) begin
            key = rand128();
            tick();
            total++;
            if (out_def !== 128'h3925841d02dc09fbdc118597196a0b32) begin
                bad++;
                $display("FAIL kat_hold cyc %0d: got %h", i, out_def);
            end
        end
    endtask

    task automatic test_kat_vectors();
        key = 128'h0;
        obs = 1'b1;
        tick();
        obs = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        total++;
        if (out_zero !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin
            bad++;
            $display("FAIL kat_zero: got %h want 66e94bd4ef8a2c3b884cfa59ca342b2e", out_zero);
        end
        total++;
        if (out_def !== aes_model(PT_DEF, 128'h0)) begin
            bad++;
            $display("FAIL kat_zero_def_inst: got %h want %h", out_def, aes_model(PT_DEF, 128'h0));
        end
        tick();
        key = 128'h000102030405060708090a0b0c0d0e0f;
        obs = 1'b1;
        tick();
        obs = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        total++;
        if (out_fips !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            bad++;
            $display("FAIL kat_fips: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", out_fips);
        end
        tick();
    endtask

    task automatic test_random_run();
        for (int it = 0; it < 6; it++) begin
            logic [127:0] k = rand128();
            logic [127:0] prev = out_def;
            key = k;
            obs = 1'b1;
            tick();
            for (int e = 1; e <= 10; e++) begin
                key = rand128();
                obs = 1'($urandom_range(0, 1));
                tick();
                if (e < 10) begin
                    total++;
                    if (out_def !== prev) begin
                        bad++;
                        $display("FAIL rand_early it %0d edge %0d: got %h want %h", it, e, out_def, prev);
                    end
                end
            end
            total++;
            if (out_def !== aes_model(PT_DEF, k) || out_zero !== aes_model(PT_ZERO, k)
                || out_fips !== aes_model(PT_FIPS, k)) begin
                bad++;
                $display("FAIL rand_result it %0d: got %h/%h/%h want %h/%h/%h", it, out_def, out_zero,
                         out_fips, aes_model(PT_DEF, k), aes_model(PT_ZERO, k), aes_model(PT_FIPS, k));
            end
            obs = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k0 = rand128();
        logic [127:0] k1 = rand128();
        key = k0;
        obs = 1'b1;
        tick();
        for (int e = 1; e <= 11; e++) begin
            key = (e == 11) ? k1 : rand128();
            tick();
            if (e == 10) begin
                total++;
                if (out_def !== aes_model(PT_DEF, k0)) begin
                    bad++;
                    $display("FAIL b2b_first: got %h want %h", out_def, aes_model(PT_DEF, k0));
                end
            end
        end
        obs = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            key = rand128();
            tick();
            total++;
            if (e < 10 && out_def !== aes_model(PT_DEF, k0)) begin
                bad++;
                $display("FAIL b2b_hold edge %0d: got %h want %h", e, out_def, aes_model(PT_DEF, k0));
            end else if (e == 10 && out_def !== aes_model(PT_DEF, k1)) begin
                bad++;
                $display("FAIL b2b_second: got %h want %h", out_def, aes_model(PT_DEF, k1));
            end
        end
    endtask

    task automatic test_abort();
        logic [127:0] k = rand128();
        key = rand128();
        obs = 1'b1;
        tick();
        obs = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_def !== 128'h0 || out_fips !== 128'h0) begin
            bad++;
            $display("FAIL abort_clear: got %h/%h want 0", out_def, out_fips);
        end
        key = k;
        obs = 1'b1;
        tick();
        obs = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            key = rand128();
            tick();
            total++;
            if (e < 10 && out_def !== 128'h0) begin
                bad++;
                $display("FAIL abort_early edge %0d: got %h want 0", e, out_def);
            end else if (e == 10 && out_def !== aes_model(PT_DEF, k)) begin
                bad++;
                $display("FAIL abort_reload: got %h want %h", out_def, aes_model(PT_DEF, k));
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_kat_default();
        test_kat_vectors();
        test_random_run();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
